reg_file_2r1w: RTL and testbench
================================

// Module: reg_file_2r1w
// PURPOSE
// - 32-entry register file with two read ports, one write port and an in-flight write scoreboard.
// - Sits directly downstream of the read-port-2 address mux:
//   - RA2 is driven by that mux's ReadPort2out.
//   - RA1 is driven by the R2 decode field.
// - Also produces STALL back to decode/issue when a source or destination register has a write outstanding.
// PARAMETERS
// - DATA_W    16  width of each register and of the read/write data
// - ADDR_W    5   register address width; number of registers = 2**ADDR_W
// PORTS
// - CLK          in   1       single clock; all state updates on the rising edge
// - RESET        in   1       synchronous, active-high reset
// - RA1          in   ADDR_W  read port 1 address
// - RA2          in   ADDR_W  read port 2 address (from the read-port-2 mux)
// - USE1         in   1       port 1 operand is consumed this cycle (qualifies the hazard check)
// - USE2         in   1       port 2 operand is consumed this cycle
// - RD1          out  DATA_W  registered read data, port 1
// - RD2          out  DATA_W  registered read data, port 2
// - WE           in   1       writeback enable
// - WA           in   ADDR_W  writeback address
// - WD           in   DATA_W  writeback data
// - ISSUE_VALID  in   1       instruction with a destination register issues this cycle
// - ISSUE_DEST   in   ADDR_W  destination register of the issuing instruction
// - STALL        out  1       hold decode/issue; issue is not accepted this cycle
// - PEND_CNT     out  ADDR_W+1  number of registers with a write outstanding
// BEHAVIOUR
// - Reset (RESET=1 at posedge):
//   - All registers = 0; RD1 = RD2 = 0; PEND = 0; PEND_CNT = 0.
//   - RESET dominates WE and ISSUE_VALID in the same cycle.
// - Register 0:
//   - Hardwired zero; writes to address 0 are dropped.
//   - Never marked pending; reads of address 0 always return 0.
// - Write: at posedge, if WE && WA!=0, regs[WA] <= WD.
// - Read: 1-cycle latency. At posedge, RDn <= bypass ? WD : regs[RAn], where:
//   - bypass = WE && WA==RAn && WA!=0 (write-first);
//   - RDn <= 0 when RAn==0.
// - RA1==RA2 is legal; both ports return identical data.
// - Scoreboard PEND[2**ADDR_W-1:0]:
//   - clr = WE && WA!=0 && PEND[WA].
//   - set = ISSUE_VALID && ISSUE_DEST!=0 && !STALL.
//   - set and clr on the same register in one cycle: set wins, the bit stays 1, PEND_CNT is unchanged.
//   - WE to a non-pending register writes data but leaves PEND and PEND_CNT unchanged.
// - PEND_CNT update per cycle: +1 if set (and target not pending), -1 if clr (and not re-set). Never wraps.
// - STALL (combinational from current PEND and inputs):
//   - Read hazard: (USE1 && RA1!=0 && PEND[RA1] && !(WE && WA==RA1)) | same term for port 2.
//   - WAW hazard: ISSUE_VALID && ISSUE_DEST!=0 && PEND[ISSUE_DEST] && !(WE && WA==ISSUE_DEST).
//   - A same-cycle writeback resolves a hazard via the bypass, so no stall.
//   - STALL is 0 whenever RESET is 1.
// - While STALL=1: ISSUE_VALID sets no bit; reads still occur (RD is don't-care to consumer).
// STRUCTURE
// - Shared package/header: REG_ADDR_W=5, NUM_REGS=32, DATA_W=16, REG_ZERO=5'd0.
// - Sub-module reg_scoreboard:
//   - Contains the PEND vector, PEND_CNT counter and STALL logic.
//   - Inputs: RA1/RA2/USE*/WE/WA/ISSUE_*.
// - Top contains the storage array, write logic, bypass muxes and RD registers.
// TESTING
// - Reset: preload regs, assert RESET 1 cycle with WE=1
//   -> all regs read 0, RD1=RD2=0, PEND_CNT=0, STALL=0.
// - Write/read: WE WA=3 WD=16'hBEEF; next cycle RA1=3
//   -> RD1=16'hBEEF one cycle after RA1 applied.
// - Write to r0 and bypass:
//   - WE WA=0 WD=16'h1234 -> RA2=0 reads 0.
//   - Same cycle WE WA=5 WD=16'h00AA with RA2=5 -> RD2=16'h00AA next cycle.
// - Read hazard: issue dest=7 (PEND_CNT=1); next cycle RA1=7 USE1=1
//   -> STALL=1 until WE WA=7, where STALL=0 that cycle and RD1=WD, then PEND_CNT=0.
// - WAW and set-wins: dest=9 pending, ISSUE_VALID dest=9 -> STALL=1, no set.
//   - Then WE WA=9 with ISSUE dest=9 -> STALL=0, PEND[9] stays 1, PEND_CNT stays 1.
// - Count: issue dests 1,2,3 on consecutive cycles -> PEND_CNT=3.
//   - Writebacks 2 then 1 -> 2 then 1. Reset mid-sequence -> 0.

Source files
------------

// File: rtl/reg_file_2r1w_pkg.sv
// Shared sizing constants for the 2-read/1-write register file and its scoreboard.
package reg_file_2r1w_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;
  localparam int DATA_W     = 16;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_file_2r1w_scoreboard.sv
// In-flight write scoreboard: pending bits, pending count and the issue/read stall.
// Stall is combinational from current pending state; pending state updates on the rising edge.
module reg_scoreboard
  import reg_file_2r1w_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic              USE1,
  input  logic              USE2,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic              ISSUE_VALID,
  input  logic [ADDR_W-1:0] ISSUE_DEST,
  output logic              STALL,
  output logic [ADDR_W:0]   PEND_CNT
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_next;
  logic [ADDR_W:0]  cnt_next;
  logic             haz1, haz2, waw;
  logic             set, clr, inc, dec;

  // A writeback to the same register this cycle resolves the hazard through the bypass.
  assign haz1 = USE1 && (RA1 != '0) && pend[RA1] && !(WE && (WA == RA1));
  assign haz2 = USE2 && (RA2 != '0) && pend[RA2] && !(WE && (WA == RA2));
  assign waw  = ISSUE_VALID && (ISSUE_DEST != '0) && pend[ISSUE_DEST]
                && !(WE && (WA == ISSUE_DEST));

  assign STALL = !RESET && (haz1 || haz2 || waw);
  assign set   = ISSUE_VALID && (ISSUE_DEST != '0) && !STALL;
  assign clr   = WE && (WA != '0) && pend[WA];
  assign inc   = set && !pend[ISSUE_DEST];
  assign dec   = clr && !(set && (ISSUE_DEST == WA));

  always_comb begin
    pend_next = pend;
    if (clr) pend_next[WA] = 1'b0;
    if (set) pend_next[ISSUE_DEST] = 1'b1;
    cnt_next = PEND_CNT + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend     <= '0;
      PEND_CNT <= '0;
    end else begin
      pend     <= pend_next;
      PEND_CNT <= cnt_next;
    end
  end
endmodule

// File: rtl/reg_file_2r1w.sv
// 32x16 register file, two registered read ports with write-first bypass, one write port,
// plus the in-flight write scoreboard that raises STALL toward decode/issue.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic              USE1,
  input  logic              USE2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic              ISSUE_VALID,
  input  logic [ADDR_W-1:0] ISSUE_DEST,
  output logic              STALL,
  output logic [ADDR_W:0]   PEND_CNT
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rd1_next, rd2_next;

  always_comb begin
    rd1_next = regs[RA1];
    rd2_next = regs[RA2];
    if (WE && (WA == RA1)) rd1_next = WD;
    if (WE && (WA == RA2)) rd2_next = WD;
    // r0 reads zero even when a dropped write to r0 is in flight.
    if (RA1 == '0) rd1_next = '0;
    if (RA2 == '0) rd2_next = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      RD1 <= '0;
      RD2 <= '0;
    end else begin
      if (WE && (WA != '0)) regs[WA] <= WD;
      RD1 <= rd1_next;
      RD2 <= rd2_next;
    end
  end

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .CLK         (CLK),
    .RESET       (RESET),
    .RA1         (RA1),
    .RA2         (RA2),
    .USE1        (USE1),
    .USE2        (USE2),
    .WE          (WE),
    .WA          (WA),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_DEST  (ISSUE_DEST),
    .STALL       (STALL),
    .PEND_CNT    (PEND_CNT)
  );
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: directed scenarios then random traffic against an array/popcount model.
module tb_reg_file_2r1w;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, issue_dest = '0;
  logic        use1 = 1'b0, use2 = 1'b0, we = 1'b0, issue_valid = 1'b0;
  logic [15:0] wd = '0;
  logic [15:0] rd1, rd2;
  logic        stall;
  logic [5:0]  pend_cnt;

  always #5 clk = ~clk;

  reg_file_2r1w dut (
    .CLK(clk), .RESET(reset), .RA1(ra1), .RA2(ra2), .USE1(use1), .USE2(use2),
    .RD1(rd1), .RD2(rd2), .WE(we), .WA(wa), .WD(wd),
    .ISSUE_VALID(issue_valid), .ISSUE_DEST(issue_dest),
    .STALL(stall), .PEND_CNT(pend_cnt)
  );

  typedef struct {
    logic        stall;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [5:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_regs [32];
  bit          m_pend [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model's expectation for this cycle goes to the queue.
  task automatic step(input bit rst, input bit w, input int a_w, input logic [15:0] d_w,
                      input int a1, input int a2, input bit u1, input bit u2,
                      input bit iv, input int dst);
    exp_t e;
    logic [4:0] r1, r2, aw, ds;
    bit haz;
    int cnt;
    r1 = a1[4:0]; r2 = a2[4:0]; aw = a_w[4:0]; ds = dst[4:0];
    @(posedge clk); #2;
    reset = rst; we = w; wa = aw; wd = d_w; ra1 = r1; ra2 = r2;
    use1 = u1; use2 = u2; issue_valid = iv; issue_dest = ds;

    haz = 0;
    if (u1 && r1 != 0 && m_pend[r1] && !(w && aw == r1)) haz = 1;
    if (u2 && r2 != 0 && m_pend[r2] && !(w && aw == r2)) haz = 1;
    if (iv && ds != 0 && m_pend[ds] && !(w && aw == ds)) haz = 1;
    e.stall = rst ? 1'b0 : haz;

    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
      e.rd1 = '0; e.rd2 = '0;
    end else begin
      e.rd1 = (r1 == 0) ? 16'h0 : (w && aw == r1) ? d_w : m_regs[r1];
      e.rd2 = (r2 == 0) ? 16'h0 : (w && aw == r2) ? d_w : m_regs[r2];
      if (w && aw != 0) begin m_regs[aw] = d_w; m_pend[aw] = 0; end
      if (iv && ds != 0 && !e.stall) m_pend[ds] = 1;
    end
    cnt = 0;
    for (int i = 0; i < 32; i++) cnt += int'(m_pend[i]);
    e.cnt = 6'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  // Monitor: STALL is sampled mid-cycle, registered outputs just after the edge.
  initial begin
    logic s_stall;
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      s_stall = stall;
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", {31'b0, s_stall}, {31'b0, e.stall});
        chk("rd1", {16'b0, rd1}, {16'b0, e.rd1});
        chk("rd2", {16'b0, rd2}, {16'b0, e.rd2});
        chk("pend_cnt", {26'b0, pend_cnt}, {26'b0, e.cnt});
      end
    end
  end

  initial begin
    // reset, preload, then reset with a concurrent write and read everything back
    step(1, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 16'h1111, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4, 16'h2222, 0, 0, 0, 0, 1, 6);
    step(1, 1, 4, 16'h3333, 0, 0, 0, 0, 1, 8);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 16'h0, i, i + 16, 0, 0, 0, 0);
    // write then read
    step(0, 1, 3, 16'hBEEF, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 16'h0, 3, 0, 0, 0, 0, 0);
    idle();
    // r0 write dropped; same-cycle bypass on port 2
    step(0, 1, 0, 16'h1234, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 16'h00AA, 0, 5, 0, 0, 0, 0);
    idle();
    // read hazard on r7 resolved by writeback
    step(0, 0, 0, 16'h0, 0, 0, 0, 0, 1, 7);
    step(0, 0, 0, 16'h0, 7, 0, 1, 0, 0, 0);
    step(0, 0, 0, 16'h0, 7, 0, 1, 0, 0, 0);
    step(0, 1, 7, 16'h7777, 7, 0, 1, 0, 0, 0);
    idle();
    // WAW on r9, then writeback+reissue in one cycle (set wins)
    step(0, 0, 0, 16'h0, 0, 0, 0, 0, 1, 9);
    step(0, 0, 0, 16'h0, 0, 0, 0, 0, 1, 9);
    step(0, 1, 9, 16'h9999, 0, 0, 0, 0, 1, 9);
    idle();
    step(0, 1, 9, 16'h9A9A, 9, 9, 1, 1, 0, 0);
    idle();
    // pending count up/down and reset mid-sequence
    step(0, 0, 0, 16'h0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 16'h0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 16'h0, 0, 0, 0, 0, 1, 3);
    step(0, 1, 2, 16'h0202, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 16'h0101, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 16'h0, 0, 0, 0, 0, 1, 4);
    idle();
    // random traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0, rnd_addr(), 16'($urandom),
           rnd_addr(), rnd_addr(), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, rnd_addr());
    idle();
    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
